// File: rtl/pac_pkg.sv
// Shared definitions for the Pacman sprite animation controller.
package pac_pkg;

    // Sprite edge in pixels; the address pipeline is built for 16x16 only.
    localparam int SPRITE_SIZE = 16;

    // Facing direction encoding carried on DIR.
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // 4:4:4 RGB colour word.
    typedef logic [11:0] color_t;

    // Animation phase, 0..3, selects one of four sprite ROM frames.
    typedef logic [1:0] phase_t;

    // ROM colour meaning "no sprite pixel here".
    localparam color_t COLOR_TRANSPARENT = 12'h000;

endpackage

// File: rtl/pac_anim_phase.sv
// Animation phase generator: divides moving frame strobes down to
// phase steps and cycles the phase 0->1->2->3->0.
module pac_anim_phase
    import pac_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_strobe,
    input  logic   i_moving,
    output phase_t o_phase
);

    localparam logic [3:0] LAST_COUNT = 4'(FRAMES_PER_STEP - 1);

    logic [3:0] r_strobe_cnt;
    phase_t     r_phase;

    // Count strobes only while moving; the last strobe of a step advances the phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_strobe_cnt <= 4'd0;
            r_phase      <= 2'd0;
        end else if (i_strobe && i_moving) begin
            if (r_strobe_cnt == LAST_COUNT) begin
                r_strobe_cnt <= 4'd0;
                r_phase      <= r_phase + 2'd1;
            end else begin
                r_strobe_cnt <= r_strobe_cnt + 4'd1;
            end
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/pac_anim_ctrl.sv
// Pacman sprite controller: latches position/direction once per frame,
// maps the raster pixel into rotated/mirrored sprite ROM indices (stage 1)
// and registers the ROM colour into a hit/colour output (stage 2).
module pac_anim_ctrl #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int SPRITE_SIZE     = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME_STROBE,
    input  logic        MOVING,
    input  logic [1:0]  DIR,
    input  logic [9:0]  PAC_X,
    input  logic [9:0]  PAC_Y,
    input  logic [9:0]  PIX_X,
    input  logic [9:0]  PIX_Y,
    input  logic        PIX_VALID,
    input  logic [11:0] SPRITE_RGB,
    output logic [3:0]  X_INDEX,
    output logic [3:0]  Y_INDEX,
    output logic [2:0]  FRAME_SELECT,
    output logic [11:0] PAC_RGB,
    output logic        PAC_HIT
);

    localparam logic [10:0] EDGE_LEN = 11'(SPRITE_SIZE);
    localparam logic [3:0]  LAST_IDX = 4'(SPRITE_SIZE - 1);

    // Shadow copies: only these are used by the pixel pipeline.
    logic [1:0]  r_dir_s;
    logic [9:0]  r_pac_x_s;
    logic [9:0]  r_pac_y_s;

    logic [3:0]  r_x_idx;
    logic [3:0]  r_y_idx;
    logic        r_in_win;
    pac_pkg::color_t r_pac_rgb;
    logic        r_pac_hit;

    pac_pkg::phase_t w_phase;
    logic [10:0] w_r;
    logic [10:0] w_c;
    logic        w_in_win;
    logic [3:0]  w_x_idx;
    logic [3:0]  w_y_idx;
    logic        w_hit_next;

    pac_anim_phase #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_phase (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_strobe (FRAME_STROBE),
        .i_moving (MOVING),
        .o_phase  (w_phase)
    );

    // Capture direction and position at vertical blank so nothing moves mid-frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dir_s   <= pac_pkg::DIR_RIGHT;
            r_pac_x_s <= 10'd0;
            r_pac_y_s <= 10'd0;
        end else if (FRAME_STROBE) begin
            r_dir_s   <= DIR;
            r_pac_x_s <= PAC_X;
            r_pac_y_s <= PAC_Y;
        end
    end

    // 11-bit offsets: a pixel left of/above the sprite gives a large unsigned
    // value, so a single unsigned compare rejects both sides without wrap.
    assign w_r      = {1'b0, PIX_Y} - {1'b0, r_pac_y_s};
    assign w_c      = {1'b0, PIX_X} - {1'b0, r_pac_x_s};
    assign w_in_win = PIX_VALID && (w_r < EDGE_LEN) && (w_c < EDGE_LEN);

    // Rotate/mirror the in-sprite offset into ROM row/column per direction.
    always_comb begin
        w_x_idx = 4'd0;
        w_y_idx = 4'd0;
        if (w_in_win) begin
            case (r_dir_s)
                pac_pkg::DIR_RIGHT: begin w_x_idx = w_r[3:0]; w_y_idx = w_c[3:0];            end
                pac_pkg::DIR_LEFT:  begin w_x_idx = w_r[3:0]; w_y_idx = LAST_IDX - w_c[3:0]; end
                pac_pkg::DIR_UP:    begin w_x_idx = w_c[3:0]; w_y_idx = LAST_IDX - w_r[3:0]; end
                default:            begin w_x_idx = w_c[3:0]; w_y_idx = w_r[3:0];            end
            endcase
        end
    end

    // Stage 1: register ROM address and the window flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x_idx  <= 4'd0;
            r_y_idx  <= 4'd0;
            r_in_win <= 1'b0;
        end else begin
            r_x_idx  <= w_x_idx;
            r_y_idx  <= w_y_idx;
            r_in_win <= w_in_win;
        end
    end

    assign w_hit_next = r_in_win && (SPRITE_RGB != pac_pkg::COLOR_TRANSPARENT);

    // Stage 2: register ROM colour; colour is forced transparent on a miss.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pac_hit <= 1'b0;
            r_pac_rgb <= pac_pkg::COLOR_TRANSPARENT;
        end else begin
            r_pac_hit <= w_hit_next;
            r_pac_rgb <= w_hit_next ? SPRITE_RGB : pac_pkg::COLOR_TRANSPARENT;
        end
    end

    assign X_INDEX      = r_x_idx;
    assign Y_INDEX      = r_y_idx;
    assign FRAME_SELECT = {1'b0, w_phase};
    assign PAC_RGB      = r_pac_rgb;
    assign PAC_HIT      = r_pac_hit;

endmodule

// File: tb/tb_pac_anim_ctrl.sv
// Self-checking bench for pac_anim_ctrl: directed literal cases plus
// randomized traffic against a behavioural model of the sprite pipeline.
module tb_pac_anim_ctrl;

    localparam int FPS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic        moving = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic [9:0]  pac_x = 10'd0;
    logic [9:0]  pac_y = 10'd0;
    logic [9:0]  pix_x = 10'd0;
    logic [9:0]  pix_y = 10'd0;
    logic        pix_valid = 1'b0;
    logic [11:0] sprite_rgb;
    logic [3:0]  x_index;
    logic [3:0]  y_index;
    logic [2:0]  frame_select;
    logic [11:0] pac_rgb;
    logic        pac_hit;

    // Fake sprite ROM, with an override for directed colour cases.
    logic [11:0] rom [0:3][0:15][0:15];
    logic        ov_en = 1'b0;
    logic [11:0] ov_val = 12'h000;

    assign sprite_rgb = ov_en ? ov_val : rom[frame_select[1:0]][x_index][y_index];

    pac_anim_ctrl #(
        .FRAMES_PER_STEP (FPS),
        .SPRITE_SIZE     (16)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .FRAME_STROBE (strobe),
        .MOVING       (moving),
        .DIR          (dir),
        .PAC_X        (pac_x),
        .PAC_Y        (pac_y),
        .PIX_X        (pix_x),
        .PIX_Y        (pix_y),
        .PIX_VALID    (pix_valid),
        .SPRITE_RGB   (sprite_rgb),
        .X_INDEX      (x_index),
        .Y_INDEX      (y_index),
        .FRAME_SELECT (frame_select),
        .PAC_RGB      (pac_rgb),
        .PAC_HIT      (pac_hit)
    );

    // Clock
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    int          m_steps = 0;      // moving strobes since reset
    int          m_dir = 0;
    int          m_pac_x = 0;
    int          m_pac_y = 0;
    bit          m_win = 0;
    int          m_x = 0;
    int          m_y = 0;
    bit          m_hit = 0;
    logic [11:0] m_rgb = 12'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int model_phase();
        return (m_steps / FPS) % 4;
    endfunction

    // One clock edge of the model, using the inputs held across that edge.
    task automatic model_update();
        logic [11:0] rgb;
        int r, c;
        if (rst) begin
            m_steps = 0; m_dir = 0; m_pac_x = 0; m_pac_y = 0;
            m_win = 0; m_x = 0; m_y = 0; m_hit = 0; m_rgb = 12'h000;
        end else begin
            rgb   = ov_en ? ov_val : rom[model_phase()][m_x][m_y];
            m_hit = m_win && (rgb != 12'h000);
            m_rgb = m_hit ? rgb : 12'h000;
            r = int'(pix_y) - m_pac_y;
            c = int'(pix_x) - m_pac_x;
            m_win = pix_valid && r >= 0 && r <= 15 && c >= 0 && c <= 15;
            m_x = 0;
            m_y = 0;
            if (m_win) begin
                case (m_dir)
                    0: begin m_x = r; m_y = c;      end
                    1: begin m_x = r; m_y = 15 - c; end
                    2: begin m_x = c; m_y = 15 - r; end
                    default: begin m_x = c; m_y = r; end
                endcase
            end
            if (strobe) begin
                if (moving) m_steps++;
                m_dir   = int'(dir);
                m_pac_x = int'(pac_x);
                m_pac_y = int'(pac_y);
            end
        end
    endtask

    task automatic compare_all();
        check("x_index",      32'(x_index),      32'(m_x));
        check("y_index",      32'(y_index),      32'(m_y));
        check("frame_select", 32'(frame_select), 32'(model_phase()));
        check("pac_hit",      32'(pac_hit),      32'(m_hit));
        check("pac_rgb",      32'(pac_rgb),      32'(m_rgb));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_update();
        compare_all();
    endtask

    task automatic strobe_once();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y, input bit v);
        pix_x = 10'(x);
        pix_y = 10'(y);
        pix_valid = v;
    endtask

    task automatic latch(input int d, input int x, input int y);
        dir = 2'(d);
        pac_x = 10'(x);
        pac_y = 10'(y);
        set_pix(0, 0, 1'b0);
        strobe_once();
    endtask

    int exp_fs_035 [16] = '{0,0,0,1, 1,1,1,2, 2,2,2,3, 3,3,3,0};

    initial begin
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    rom[f][i][j] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset_x_index", 32'(x_index), 0);
        check("reset_fs",      32'(frame_select), 0);
        check("reset_hit",     32'(pac_hit), 0);
        check("reset_rgb",     32'(pac_rgb), 0);
        rst = 1'b0;
        tick();

        // Phase advances every FPS moving strobes
        moving = 1'b1;
        for (int s = 0; s < 16; s++) begin
            strobe_once();
            tick();
            check("fs_step_sequence", 32'(frame_select), 32'(exp_fs_035[s]));
        end

        // Hold phase while not moving, then resume with the remaining count
        repeat (9) begin strobe_once(); tick(); end
        check("fs_before_hold", 32'(frame_select), 2);
        moving = 1'b0;
        repeat (10) begin strobe_once(); tick(); end
        check("fs_held", 32'(frame_select), 2);
        moving = 1'b1;
        repeat (2) begin strobe_once(); tick(); end
        check("fs_resume_wait", 32'(frame_select), 2);
        strobe_once();
        check("fs_resume_step", 32'(frame_select), 3);
        moving = 1'b0;

        // Left-facing index mapping and window edge
        ov_en = 1'b1;
        ov_val = 12'hFF0;
        latch(1, 100, 50);
        set_pix(103, 55, 1'b1);
        tick();
        check("left_x_index", 32'(x_index), 5);
        check("left_y_index", 32'(y_index), 12);
        tick();
        check("left_hit", 32'(pac_hit), 1);
        check("left_rgb", 32'(pac_rgb), 32'h0FF0);
        set_pix(116, 55, 1'b1);
        tick();
        tick();
        check("edge16_hit", 32'(pac_hit), 0);
        check("edge16_rgb", 32'(pac_rgb), 0);

        // Up and down mappings
        latch(2, 100, 50);
        set_pix(100, 50, 1'b1);
        tick();
        check("up_x_index", 32'(x_index), 0);
        check("up_y_index", 32'(y_index), 15);
        latch(3, 100, 50);
        set_pix(102, 57, 1'b1);
        tick();
        check("down_x_index", 32'(x_index), 2);
        check("down_y_index", 32'(y_index), 7);

        // No wrap near the right screen edge; transparent colour
        latch(0, 1020, 50);
        set_pix(0, 50, 1'b1);
        tick();
        check("nowrap_y_index", 32'(y_index), 0);
        tick();
        check("nowrap_hit", 32'(pac_hit), 0);
        set_pix(1023, 50, 1'b1);
        tick();
        check("edge_right_y_index", 32'(y_index), 3);
        tick();
        check("opaque_hit", 32'(pac_hit), 1);
        check("opaque_rgb", 32'(pac_rgb), 32'h0FF0);
        ov_val = 12'h000;
        tick();
        tick();
        check("transparent_hit", 32'(pac_hit), 0);
        check("transparent_rgb", 32'(pac_rgb), 0);

        // Direction change without a strobe is ignored
        ov_val = 12'hFF0;
        latch(0, 100, 50);
        set_pix(103, 55, 1'b1);
        tick();
        check("right_x_index", 32'(x_index), 5);
        check("right_y_index", 32'(y_index), 3);
        dir = 2'd2;
        pac_x = 10'd0;
        tick();
        check("midframe_x_index", 32'(x_index), 5);
        check("midframe_y_index", 32'(y_index), 3);
        check("pre_reset_fs",  32'(frame_select), 3);
        check("pre_reset_hit", 32'(pac_hit), 1);

        // Reset at phase 3 clears everything at the next edge
        rst = 1'b1;
        tick();
        check("rst_x_index", 32'(x_index), 0);
        check("rst_y_index", 32'(y_index), 0);
        check("rst_fs",      32'(frame_select), 0);
        check("rst_hit",     32'(pac_hit), 0);
        check("rst_rgb",     32'(pac_rgb), 0);
        rst = 1'b0;
        ov_en = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst    = ($urandom_range(0, 299) == 0);
            strobe = ($urandom_range(0, 7) == 0);
            moving = ($urandom_range(0, 3) != 0);
            dir    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                pac_x = 10'($urandom_range(0, 1023));
                pac_y = 10'($urandom_range(0, 1023));
            end
            set_pix((m_pac_x + int'($urandom_range(0, 19)) - 2) & 1023,
                    (m_pac_y + int'($urandom_range(0, 19)) - 2) & 1023,
                    $urandom_range(0, 7) != 0);
            ov_en  = ($urandom_range(0, 31) == 0);
            ov_val = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
